// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state type, flush value and state-derivation helper for the skid pipeline stage
package pipe_pkg;

    typedef enum logic [1:0] {
        PS_EMPTY = 2'd0,
        PS_BUSY  = 2'd1,
        PS_FULL  = 2'd2
    } pipe_state_t;

    localparam int PIPE_FLUSH_VALUE = 0;

    function automatic pipe_state_t pipe_state(input logic main_v, input logic skid_v);
        return !main_v ? PS_EMPTY : skid_v ? PS_FULL : PS_BUSY;
    endfunction

endpackage

// File: rtl/pipe_stage_skid_if.sv
// pipe_stage_skid_if: upstream and downstream valid/ready handshake of the skid stage
interface pipe_stage_skid_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/pipe_dreg.sv
// pipe_dreg: data register with enable and a synchronous clear that overrides the enable
module pipe_dreg
    import pipe_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // clear wins over load so a flush always leaves the register at the flush value
    always_ff @(posedge clk) begin
        if (rst || clr) q <= WIDTH'(PIPE_FLUSH_VALUE);
        else if (en)    q <= d;
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: registered pipeline stage with one-entry skid buffer, flush and saturating stall counter
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    pipe_stage_skid_if.slave  pipe,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    pipe_state_t      state;
    logic             main_v_q, main_v_d;
    logic             skid_v_q, skid_v_d;
    logic             in_ready_q;
    logic             accept, deliver;
    logic             main_en, skid_en;
    logic [WIDTH-1:0] main_q, main_d, skid_q;
    logic [CNT_W-1:0] stall_q, stall_d;

    // next-state of the valid bits, register loads and stall counter from the derived state
    always_comb begin
        state    = pipe_state(main_v_q, skid_v_q);
        accept   = pipe.in_valid & in_ready_q;
        deliver  = main_v_q & pipe.out_ready;
        main_en  = (accept & ((state == PS_EMPTY) | deliver)) | ((state == PS_FULL) & deliver);
        skid_en  = accept & (state == PS_BUSY) & !deliver;
        main_d   = (state == PS_FULL) ? skid_q : pipe.in_data;
        main_v_d = flush_i ? 1'b0 : (state == PS_FULL) | accept | (main_v_q & !deliver);
        skid_v_d = flush_i ? 1'b0 : (state == PS_FULL) ? !deliver : skid_en;
        stall_d  = (main_v_q & !pipe.out_ready & (stall_q != '1)) ? stall_q + CNT_W'(1) : stall_q;
    end

    // valid bits, registered ready (mirror of the skid slot being free) and stall counter
    always_ff @(posedge clk) begin
        if (rst) begin
            main_v_q   <= 1'b0;
            skid_v_q   <= 1'b0;
            in_ready_q <= 1'b1;
            stall_q    <= '0;
        end else begin
            main_v_q   <= main_v_d;
            skid_v_q   <= skid_v_d;
            in_ready_q <= !skid_v_d;
            stall_q    <= stall_d;
        end
    end

    pipe_dreg #(.WIDTH(WIDTH)) u_main (
        .clk (clk),
        .rst (rst),
        .clr (flush_i),
        .en  (main_en),
        .d   (main_d),
        .q   (main_q)
    );

    pipe_dreg #(.WIDTH(WIDTH)) u_skid (
        .clk (clk),
        .rst (rst),
        .clr (flush_i),
        .en  (skid_en),
        .d   (pipe.in_data),
        .q   (skid_q)
    );

    assign pipe.in_ready  = in_ready_q;
    assign pipe.out_valid = main_v_q;
    assign pipe.out_data  = main_q;
    assign stall_cnt_o    = stall_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: queue-based reference model plus directed and random handshake stimulus
module tb_pipe_stage_skid;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic [15:0] stall16;
    logic [3:0]  stall4;
    int          n_cmp = 0;
    int          n_bad = 0;

    pipe_stage_skid_if #(.WIDTH(32)) bus ();
    pipe_stage_skid_if #(.WIDTH(32)) bus4 ();

    assign bus4.in_valid  = bus.in_valid;
    assign bus4.in_data   = bus.in_data;
    assign bus4.out_ready = bus.out_ready;

    pipe_stage_skid #(.WIDTH(32), .CNT_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush),
        .pipe        (bus),
        .stall_cnt_o (stall16)
    );

    pipe_stage_skid #(.WIDTH(32), .CNT_W(4)) dut4 (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush),
        .pipe        (bus4),
        .stall_cnt_o (stall4)
    );

    always #5 clk = ~clk;

    // reference model: the stage is a FIFO of at most two words
    logic [31:0] mq[$];
    logic [31:0] m_last = 32'h0;
    int unsigned m_stall = 0;
    bit          m_ov, m_ir;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_last  = 32'h0;
            m_stall = 0;
        end else begin
            m_ov = mq.size() > 0;
            m_ir = mq.size() < 2;
            if (m_ov && !bus.out_ready) m_stall++;
            if (flush) begin
                mq.delete();
                m_last = 32'h0;
            end else begin
                if (m_ov && bus.out_ready) m_last = mq.pop_front();
                if (bus.in_valid && m_ir) mq.push_back(bus.in_data);
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [63:0] sat(input int unsigned v, input int unsigned mx);
        return (v > mx) ? 64'(mx) : 64'(v);
    endfunction

    // every cycle both instances must match the model
    always @(negedge clk) begin
        chk("out_valid", 64'(bus.out_valid), 64'(mq.size() > 0));
        chk("out_data", 64'(bus.out_data), 64'(mq.size() > 0 ? mq[0] : m_last));
        chk("in_ready", 64'(bus.in_ready), 64'(mq.size() < 2));
        chk("stall_cnt16", 64'(stall16), sat(m_stall, 65535));
        chk("out_valid4", 64'(bus4.out_valid), 64'(mq.size() > 0));
        chk("out_data4", 64'(bus4.out_data), 64'(mq.size() > 0 ? mq[0] : m_last));
        chk("in_ready4", 64'(bus4.in_ready), 64'(mq.size() < 2));
        chk("stall_cnt4", 64'(stall4), sat(m_stall, 15));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic r);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = r;
    endtask

    initial begin
        drive(1'b0, 32'h0, 1'b0);
        tick();
        tick();
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_data", 64'(bus.out_data), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_stall", 64'(stall16), 64'd0);
        rst = 1'b0;

        drive(1'b1, 32'h11, 1'b1); tick();
        chk("stream_11", 64'(bus.out_data), 64'h11);
        drive(1'b1, 32'h22, 1'b1); tick();
        chk("stream_22", 64'(bus.out_data), 64'h22);
        drive(1'b1, 32'h33, 1'b1); tick();
        chk("stream_33", 64'(bus.out_data), 64'h33);
        drive(1'b0, 32'h0, 1'b1); tick();
        chk("drain_valid", 64'(bus.out_valid), 64'd0);
        chk("drain_hold", 64'(bus.out_data), 64'h33);
        chk("stream_stall", 64'(stall16), 64'd0);

        drive(1'b1, 32'hA0, 1'b0); tick();
        chk("bp_a0", 64'(bus.out_data), 64'hA0);
        drive(1'b1, 32'hA1, 1'b0); tick();
        chk("bp_ready_low", 64'(bus.in_ready), 64'd0);
        chk("bp_hold_a0", 64'(bus.out_data), 64'hA0);
        drive(1'b0, 32'h0, 1'b0); tick(); tick();
        chk("bp_stall3", 64'(stall16), 64'd3);
        drive(1'b0, 32'h0, 1'b1); tick();
        chk("bp_a1", 64'(bus.out_data), 64'hA1);
        chk("bp_ready_back", 64'(bus.in_ready), 64'd1);
        tick();
        chk("bp_empty", 64'(bus.out_valid), 64'd0);
        chk("bp_stall_keep", 64'(stall16), 64'd3);

        drive(1'b1, 32'h01, 1'b0); tick();
        drive(1'b1, 32'h02, 1'b0); tick();
        chk("full_ready", 64'(bus.in_ready), 64'd0);
        drive(1'b1, 32'hBEEF, 1'b0); flush = 1'b1; tick();
        flush = 1'b0;
        chk("flush_valid", 64'(bus.out_valid), 64'd0);
        chk("flush_data", 64'(bus.out_data), 64'd0);
        chk("flush_ready", 64'(bus.in_ready), 64'd1);
        chk("flush_stall", 64'(stall16), 64'd5);
        drive(1'b0, 32'h0, 1'b1); tick();
        chk("no_beef", 64'(bus.out_valid), 64'd0);

        drive(1'b1, 32'h55, 1'b0); tick();
        drive(1'b1, 32'h66, 1'b0); rst = 1'b1; flush = 1'b1; tick();
        rst = 1'b0; flush = 1'b0;
        chk("rst_busy_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_busy_data", 64'(bus.out_data), 64'd0);
        chk("rst_busy_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_busy_stall", 64'(stall16), 64'd0);

        drive(1'b1, 32'h77, 1'b0); tick();
        drive(1'b0, 32'h0, 1'b0);
        repeat (20) tick();
        chk("sat_stall4", 64'(stall4), 64'd15);
        chk("sat_stall16", 64'(stall16), 64'd20);
        tick();
        chk("sat_hold4", 64'(stall4), 64'd15);
        drive(1'b0, 32'h0, 1'b1); tick();

        for (int i = 0; i < 10000; i++) begin
            drive(($urandom % 4) != 0, $urandom, ($urandom % 3) != 0);
            flush = ($urandom % 200) == 0;
            rst   = ($urandom % 1500) == 0;
            tick();
        end
        drive(1'b0, 32'h0, 1'b1); flush = 1'b0; rst = 1'b0;
        tick(); tick(); tick();
        chk("final_empty", 64'(bus.out_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
